// File: rtl/rx_dma_cmdgen_if.sv
// PHY RX FIFO read side and master command FIFO write side of the RX DMA command generator.
interface rx_dma_cmdgen_if;
  logic [17:0] phy_dout;
  logic        phy_empty;
  logic        phy_rd_en;
  logic [17:0] mst_din;
  logic        mst_full;
  logic        mst_wr_en;

  modport master (
    input  phy_dout, phy_empty, mst_full,
    output phy_rd_en, mst_din, mst_wr_en
  );

  modport slave (
    output phy_dout, phy_empty, mst_full,
    input  phy_rd_en, mst_din, mst_wr_en
  );
endinterface

// File: rtl/rx_dma_cmdgen.sv
// Turns PHY RX frames into master write commands: payload chunks into a host ring,
// followed by a 4-DW record header (length, trunc flag, timestamp) that commits the frame.
module rx_dma_cmdgen #(
  parameter int CHUNK_HW  = 64,
  parameter int MAX_FRAME = 2032
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [63:0]          global_counter,
  rx_dma_cmdgen_if.master      bus,
  input  logic                 dma_enable,
  input  logic [19:0]          dma_length,
  input  logic [29:0]          dma_addr_start,
  output logic [29:0]          dma_addr_cur,
  output logic [15:0]          frame_count
);
  localparam int          IDX_W  = $clog2(CHUNK_HW);
  localparam int          CNT_W  = IDX_W + 1;
  localparam logic [15:0] MAX_HW = 16'(MAX_FRAME / 2);

  typedef enum logic [3:0] {
    IDLE, COLLECT, CMD_H0, CMD_H1, CMD_H2, CMD_DATA,
    REC_H0, REC_H1, REC_H2, REC_DATA, DISCARD
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      chunk_mem [CHUNK_HW];
  logic             en_q, vld_p0, trunc_q, last_q;
  logic [CNT_W-1:0] hw_cnt_q, emit_idx_q;
  logic [15:0]      frame_hw_q, frame_count_q;
  logic [63:0]      ts_q;
  logic [29:0]      rec_base_q, pay_ptr_q, addr_cur_q;

  logic             in_data, in_last, capture_ok, frm_start, take, store, chunk_go;
  logic             emit_last, rec_last, rd_en, wr_en;
  logic [CNT_W-1:0] hw_nxt, len_dw;
  logic [CNT_W:0]   last_idx;
  logic [30:0]      base_end, ring_end;
  logic [29:0]      base_sel;
  logic [15:0]      len_b, emit_word, rec_word;
  logic [17:0]      din;

  function automatic logic [29:0] ceil_dw(input logic [15:0] bytes);
    return 30'(({1'b0, bytes} + 17'd3) >> 2);
  endfunction

  assign in_data    = bus.phy_dout[17];
  assign in_last    = bus.phy_dout[16];
  assign capture_ok = dma_enable && (dma_length >= 20'd512);
  assign frm_start  = (state_q == IDLE) && vld_p0 && in_data;
  assign take       = vld_p0 && ((frm_start && capture_ok) || (state_q == COLLECT));
  assign store      = take && (frame_hw_q < MAX_HW);
  assign hw_nxt     = hw_cnt_q + CNT_W'(store);
  assign chunk_go   = take && (in_last || (hw_nxt == CNT_W'(CHUNK_HW)));

  // A record must fit in front of the ring end, otherwise it restarts at the ring base.
  assign base_end = {1'b0, addr_cur_q} + 31'd512;
  assign ring_end = {1'b0, dma_addr_start} + {11'b0, dma_length};
  assign base_sel = (base_end > ring_end) ? dma_addr_start : addr_cur_q;

  assign len_dw    = CNT_W'(({1'b0, hw_cnt_q} + (CNT_W+1)'(1)) >> 1);
  assign last_idx  = {len_dw, 1'b0} - (CNT_W+1)'(1);
  assign emit_last = ({1'b0, emit_idx_q} == last_idx);
  assign emit_word = (emit_idx_q < hw_cnt_q) ? chunk_mem[emit_idx_q[IDX_W-1:0]] : 16'h0000;
  assign rec_last  = (emit_idx_q[2:0] == 3'd7);
  assign len_b     = {frame_hw_q[14:0], 1'b0};

  always_comb begin
    rec_word = 16'h0000;
    case (emit_idx_q[2:0])
      3'd0:    rec_word = len_b;
      3'd1:    rec_word = {15'b0, trunc_q};
      3'd4:    rec_word = ts_q[15:0];
      3'd5:    rec_word = ts_q[31:16];
      3'd6:    rec_word = ts_q[47:32];
      3'd7:    rec_word = ts_q[63:48];
      default: rec_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    din     = '0;
    case (state_q)
      IDLE: begin
        rd_en = !vld_p0 && !bus.phy_empty;
        if (frm_start) begin
          if (!capture_ok)   state_d = in_last ? IDLE : DISCARD;
          else if (chunk_go) state_d = CMD_H0;
          else               state_d = COLLECT;
        end
      end
      COLLECT: begin
        rd_en = !vld_p0 && !bus.phy_empty;
        if (chunk_go) state_d = (hw_nxt == '0) ? REC_H0 : CMD_H0;
      end
      CMD_H0: begin
        din   = {2'b10, 6'b0, 10'(len_dw)};
        wr_en = !bus.mst_full;
        if (wr_en) state_d = CMD_H1;
      end
      CMD_H1: begin
        din   = {2'b00, pay_ptr_q[29:14]};
        wr_en = !bus.mst_full;
        if (wr_en) state_d = CMD_H2;
      end
      CMD_H2: begin
        din   = {2'b00, pay_ptr_q[13:0], 2'b00};
        wr_en = !bus.mst_full;
        if (wr_en) state_d = CMD_DATA;
      end
      CMD_DATA: begin
        din   = {(emit_last ? 2'b01 : 2'b00), emit_word};
        wr_en = !bus.mst_full;
        if (wr_en && emit_last) state_d = last_q ? REC_H0 : COLLECT;
      end
      REC_H0: begin
        din   = {2'b10, 6'b0, 10'd4};
        wr_en = !bus.mst_full;
        if (wr_en) state_d = REC_H1;
      end
      REC_H1: begin
        din   = {2'b00, rec_base_q[29:14]};
        wr_en = !bus.mst_full;
        if (wr_en) state_d = REC_H2;
      end
      REC_H2: begin
        din   = {2'b00, rec_base_q[13:0], 2'b00};
        wr_en = !bus.mst_full;
        if (wr_en) state_d = REC_DATA;
      end
      REC_DATA: begin
        din   = {(rec_last ? 2'b01 : 2'b00), rec_word};
        wr_en = !bus.mst_full;
        if (wr_en && rec_last) state_d = IDLE;
      end
      DISCARD: begin
        rd_en = !vld_p0 && !bus.phy_empty;
        if (vld_p0 && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.phy_rd_en = rd_en && en_q;
  assign bus.mst_wr_en = wr_en;
  assign bus.mst_din   = din;
  assign dma_addr_cur  = addr_cur_q;
  assign frame_count   = frame_count_q;

  // p0: PHY word popped last cycle is valid now; control state updates here.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      vld_p0        <= 1'b0;
      hw_cnt_q      <= '0;
      emit_idx_q    <= '0;
      frame_hw_q    <= '0;
      trunc_q       <= 1'b0;
      last_q        <= 1'b0;
      frame_count_q <= '0;
      addr_cur_q    <= dma_addr_start;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      vld_p0  <= bus.phy_rd_en;
      if (take) begin
        hw_cnt_q <= hw_nxt;
        if (store) frame_hw_q <= frame_hw_q + 16'd1;
        else       trunc_q    <= 1'b1;
        if (in_last) last_q <= 1'b1;
      end
      if (wr_en && (state_q == CMD_DATA)) begin
        emit_idx_q <= emit_last ? '0 : emit_idx_q + CNT_W'(1);
        if (emit_last) hw_cnt_q <= '0;
      end
      if (wr_en && (state_q == REC_DATA)) begin
        emit_idx_q <= rec_last ? '0 : emit_idx_q + CNT_W'(1);
        if (rec_last) begin
          addr_cur_q    <= rec_base_q + 30'd4 + ceil_dw(len_b);
          frame_count_q <= frame_count_q + 16'd1;
          frame_hw_q    <= '0;
          trunc_q       <= 1'b0;
          last_q        <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (frm_start && capture_ok) begin
      ts_q       <= global_counter;
      rec_base_q <= base_sel;
      pay_ptr_q  <= base_sel + 30'd4;
    end else if (wr_en && (state_q == CMD_DATA) && emit_last) begin
      pay_ptr_q  <= pay_ptr_q + 30'(len_dw);
    end
    if (store) chunk_mem[hw_cnt_q[IDX_W-1:0]] <= bus.phy_dout[15:0];
  end
endmodule

// File: tb/tb_rx_dma_cmdgen.sv
// Bench for rx_dma_cmdgen: PHY FIFO model, scoreboard of expected master words, frame table.
module tb_rx_dma_cmdgen;
  localparam int CHW   = 64;
  localparam int MAXHW = 1016;
  localparam logic [29:0] S0 = 30'h0100_0000;
  localparam logic [29:0] S1 = 30'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] gc;
  logic        en;
  logic [19:0] len;
  logic [29:0] start;
  logic [29:0] cur;
  logic [15:0] fcnt;

  rx_dma_cmdgen_if bus();

  rx_dma_cmdgen dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .global_counter(gc), .bus(bus),
    .dma_enable(en), .dma_length(len), .dma_addr_start(start),
    .dma_addr_cur(cur), .frame_count(fcnt)
  );

  always #4 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] phy_q[$];
  logic [17:0] exp_q[$];
  bit          stall = 1'b0;
  bit          sb_off = 1'b1;
  bit          rd_s = 1'b0;
  int          wr_total = 0;
  int          h0_cnt = 0;
  logic [29:0] m_cur;

  typedef struct {
    int nbytes;
    bit en;
    bit stall;
    int exp_cmds;
    int exp_adv;
  } vec_t;
  vec_t vt[8];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(int f, int k);
    return 16'((f << 12) ^ (k * 291) ^ 23130);
  endfunction

  function automatic void push_cmd(logic [29:0] a, int ldw);
    exp_q.push_back({2'b10, 6'b0, 10'(ldw)});
    exp_q.push_back({2'b00, a[29:14]});
    exp_q.push_back({2'b00, a[13:0], 2'b00});
  endfunction

  function automatic void model_frame(int nb, int f, logic [63:0] ts);
    int          stored, n, ldw;
    bit          tr;
    logic [29:0] b, p;
    logic [15:0] hw [8];
    stored = nb / 2;
    tr = 1'b0;
    if (stored > MAXHW) begin
      stored = MAXHW;
      tr = 1'b1;
    end
    b = m_cur;
    if ({1'b0, m_cur} + 31'd512 > {1'b0, start} + 31'(len)) b = start;
    p = b + 30'd4;
    for (int off = 0; off < stored; off += CHW) begin
      n   = (stored - off > CHW) ? CHW : stored - off;
      ldw = (n + 1) / 2;
      push_cmd(p, ldw);
      for (int i = 0; i < 2 * ldw; i++)
        exp_q.push_back({((i == 2 * ldw - 1) ? 2'b01 : 2'b00), ((i < n) ? pat(f, off + i) : 16'h0000)});
      p = p + 30'(ldw);
    end
    hw = '{16'(2 * stored), {15'b0, tr}, 16'h0, 16'h0, ts[15:0], ts[31:16], ts[47:32], ts[63:48]};
    push_cmd(b, 4);
    for (int i = 0; i < 8; i++) exp_q.push_back({((i == 7) ? 2'b01 : 2'b00), hw[i]});
    m_cur = b + 30'd4 + 30'((2 * stored + 3) / 4);
  endfunction

  // PHY FIFO model: the pop seen at an edge presents the word 1 ns later.
  always @(posedge clk) begin
    #1;
    if (rd_s) begin
      if (phy_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL phy_pop_empty: pop with empty FIFO, required none");
      end else begin
        bus.phy_dout = phy_q.pop_front();
      end
    end
    bus.phy_empty = (phy_q.size() == 0);
    bus.mst_full  = stall ? ~bus.mst_full : 1'b0;
  end

  always @(negedge clk) begin
    rd_s = bus.phy_rd_en;
    if (rst_n && !sb_off && bus.mst_wr_en) begin
      wr_total++;
      if (bus.mst_din[17:16] == 2'b10) h0_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %05h, required no write", bus.mst_din);
      end else begin
        chk("mst_din", 64'(bus.mst_din), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_done();
    int c;
    c = 0;
    while ((phy_q.size() != 0 || exp_q.size() != 0) && c < 20000) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (c >= 20000) begin
      errors++;
      $display("FAIL drain_timeout: phy left %0d exp left %0d, required 0", phy_q.size(), exp_q.size());
    end
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic push_frame(int f, int nb);
    phy_q.push_back(18'h0_1234);
    for (int k = 0; k < nb / 2; k++)
      phy_q.push_back({1'b1, (k == nb / 2 - 1), pat(f, k)});
  endtask

  task automatic run_frame(int f, int nb, bit e, bit st);
    logic [63:0] ts;
    ts = {16'hD000 + 16'(f), 16'hC222, 16'hB111, 16'hA000 + 16'(f)};
    @(posedge clk);
    #2;
    en = e;
    stall = st;
    gc = ts;
    h0_cnt = 0;
    if (e && len >= 20'd512) model_frame(nb, f, ts);
    push_frame(f, nb);
    wait_done();
    stall = 1'b0;
  endtask

  task automatic enter_reset(logic [29:0] s, logic [19:0] l);
    @(posedge clk);
    #2;
    sb_off = 1'b1;
    rst_n = 1'b0;
    start = s;
    len = l;
    phy_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [29:0] cur_ref;
    int          cnt_ref, wr0, c;
    vt[0] = '{60, 1'b1, 1'b0, 1, 19};
    vt[1] = '{200, 1'b1, 1'b0, 2, 54};
    vt[2] = '{60, 1'b1, 1'b1, 1, 19};
    vt[3] = '{3000, 1'b1, 1'b0, 16, 512};
    vt[4] = '{62, 1'b1, 1'b0, 1, 20};
    vt[5] = '{128, 1'b1, 1'b0, 1, 36};
    vt[6] = '{130, 1'b1, 1'b1, 2, 37};
    vt[7] = '{60, 1'b0, 1'b0, 0, 0};

    en = 1'b0; gc = '0; len = 20'd4096; start = S0;
    bus.phy_dout = '0; bus.phy_empty = 1'b1; bus.mst_full = 1'b0;
    phy_q.push_back(18'h0_0001);
    phy_q.push_back(18'h1_0002);
    phy_q.push_back(18'h0_0003);
    repeat (5) @(posedge clk);
    #2;
    chk("rst_phy_rd_en", 64'(bus.phy_rd_en), 64'd0);
    chk("rst_mst_wr_en", 64'(bus.mst_wr_en), 64'd0);
    chk("rst_mst_din", 64'(bus.mst_din), 64'd0);
    chk("rst_frame_count", 64'(fcnt), 64'd0);
    chk("rst_addr_cur", 64'(cur), 64'(S0));
    chk("rst_no_pop", 64'(phy_q.size()), 64'd3);
    rst_n = 1'b1;
    sb_off = 1'b0;
    m_cur = S0;
    cur_ref = S0;
    cnt_ref = 0;

    for (int i = 0; i < 8; i++) begin
      run_frame(i + 1, vt[i].nbytes, vt[i].en, vt[i].stall);
      cur_ref = cur_ref + 30'(vt[i].exp_adv);
      if (vt[i].en) cnt_ref++;
      chk($sformatf("addr_cur_vec%0d", i), 64'(cur), 64'(cur_ref));
      chk($sformatf("frame_count_vec%0d", i), 64'(fcnt), 64'(cnt_ref));
      chk($sformatf("h0_count_vec%0d", i), 64'(h0_cnt), 64'(vt[i].exp_cmds + (vt[i].en ? 1 : 0)));
    end

    // Ring of 1024 DW with the write pointer 600 DW in: next record must wrap to the base.
    enter_reset(S1 + 30'd600, 20'd1024);
    chk("rst_load_cur", 64'(cur), 64'(S1 + 30'd600));
    rst_n = 1'b1;
    start = S1;
    sb_off = 1'b0;
    m_cur = S1 + 30'd600;

    wr0 = wr_total;
    en = 1'b0;
    for (int f = 20; f < 23; f++) push_frame(f, 60 + 2 * f);
    wait_done();
    chk("disabled_writes", 64'(wr_total - wr0), 64'd0);
    chk("disabled_drained", 64'(phy_q.size()), 64'd0);
    chk("disabled_frame_count", 64'(fcnt), 64'd0);

    len = 20'd256;
    run_frame(30, 60, 1'b1, 1'b0);
    chk("short_ring_writes", 64'(wr_total - wr0), 64'd0);
    chk("short_ring_count", 64'(fcnt), 64'd0);
    chk("short_ring_cur", 64'(cur), 64'(S1 + 30'd600));

    len = 20'd1024;
    run_frame(31, 60, 1'b1, 1'b0);
    chk("wrap_cur", 64'(cur), 64'(S1 + 30'd19));
    chk("wrap_count", 64'(fcnt), 64'd1);

    // Reset in the middle of a frame's payload commands.
    @(posedge clk);
    #2;
    en = 1'b1;
    model_frame(200, 40, gc);
    push_frame(40, 200);
    wr0 = wr_total;
    c = 0;
    while (wr_total - wr0 < 10 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (c >= 5000) begin
      errors++;
      $display("FAIL midframe_timeout: writes %0d, required 10", wr_total - wr0);
    end
    enter_reset(S0, 20'd4096);
    chk("midrst_frame_count", 64'(fcnt), 64'd0);
    chk("midrst_wr_en", 64'(bus.mst_wr_en), 64'd0);
    chk("midrst_rd_en", 64'(bus.phy_rd_en), 64'd0);
    rst_n = 1'b1;
    sb_off = 1'b0;
    m_cur = S0;
    run_frame(41, 60, 1'b1, 1'b0);
    chk("after_midrst_cur", 64'(cur), 64'(S0 + 30'd19));
    chk("after_midrst_count", 64'(fcnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
